// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, word-indexed instruction memory with a
// write port, IF/ID pipeline register and saturating fetch/stall counters.
module instruction_fetch_unit #(
  parameter int unsigned           ADDR_W    = 32,
  parameter int unsigned           DATA_W    = 32,
  parameter int unsigned           MEM_WORDS = 64,
  parameter logic [ADDR_W-1:0]     RESET_PC  = '0,
  parameter logic [DATA_W-1:0]     NOP_INSTR = DATA_W'(1),
  parameter int unsigned           CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic              id_valid,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              rd_in_range;
  logic              wr_in_range;
  logic [DATA_W-1:0] rd_word;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] instr_d;
  logic [ADDR_W-1:0] pc_plus4_d;
  logic              valid_d;
  logic [CNT_W-1:0]  fetch_count_d;
  logic [CNT_W-1:0]  stall_count_d;

  // Byte-offset bits carry no information for word-aligned fetch and writes.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{redirect_addr[1:0], imem_waddr[1:0]};

  assign rd_idx      = pc_out[ADDR_W-1:2];
  assign wr_idx      = imem_waddr[ADDR_W-1:2];
  assign rd_in_range = 64'(rd_idx) < 64'(MEM_WORDS);
  assign wr_in_range = 64'(wr_idx) < 64'(MEM_WORDS);
  assign rd_word     = rd_in_range ? mem[rd_idx[MEM_AW-1:0]] : NOP_INSTR;
  assign pc_plus4    = pc_out + ADDR_W'(4);

  // Memory is not reset; writes land on the edge so a same-cycle read sees old data.
  always_ff @(posedge clk) begin
    if (imem_we && wr_in_range) begin
      mem[wr_idx[MEM_AW-1:0]] <= imem_wdata;
    end
  end

  // Next-state selection: redirect beats stall, stall beats advance.
  always_comb begin
    pc_d          = pc_out;
    instr_d       = id_instr;
    pc_plus4_d    = id_pc_plus4;
    valid_d       = id_valid;
    fetch_count_d = fetch_count;
    stall_count_d = stall_count;
    if (redirect_valid) begin
      pc_d       = {redirect_addr[ADDR_W-1:2], 2'b00};
      instr_d    = NOP_INSTR;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (stall) begin
      if (stall_count != '1) begin
        stall_count_d = stall_count + CNT_W'(1);
      end
    end else begin
      pc_d       = pc_plus4;
      instr_d    = rd_word;
      pc_plus4_d = pc_plus4;
      valid_d    = 1'b1;
      if (fetch_count != '1) begin
        fetch_count_d = fetch_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out      <= RESET_PC;
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      pc_out      <= pc_d;
      id_instr    <= instr_d;
      id_pc_plus4 <= pc_plus4_d;
      id_valid    <= valid_d;
      fetch_count <= fetch_count_d;
      stall_count <= stall_count_d;
    end
  end

endmodule
